// File: rtl/channel_receive.sv
// channel_receive: receive half of a rendezvous channel. Reads the channel's waiting-pid
// word and either parks the receiver there or takes a waiting sender's message.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 16
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module channel_receive #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrBits-1:0] channel,
    input  logic [addrBits-1:0] rxPid,
    output logic [addrBits-1:0] address,
    output logic                readWriteMode,
    output logic [dataBits-1:0] dataIn,
    input  logic [dataBits-1:0] dataOut,
    output logic                finished,
    output logic                shouldScheduleSender,
    output logic                shouldDescheduleReceiver,
    output logic [addrBits-1:0] scheduleTxPid,
    output logic [dataBits-1:0] deliveredMessage,
    output logic                error,
    output logic [2:0]          dbg_state
);

    // Handshake: start is a one-cycle request honoured only in S_IDLE; finished is a
    // one-cycle completion pulse and the next start may arrive the cycle after it.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ_PID  = 3'd1,
        S_CHECK     = 3'd2,
        S_WRITE_PID = 3'd3,
        S_READ_MSG  = 3'd4,
        S_LATCH_MSG = 3'd5,
        S_CLEAR     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [addrBits-1:0] chan_q, chan_d;
    logic [addrBits-1:0] pid_q, pid_d;
    logic [addrBits-1:0] address_q, address_d;
    logic                rw_q, rw_d;
    logic [dataBits-1:0] data_in_q, data_in_d;
    logic                finished_q, finished_d;
    logic                sched_q, sched_d;
    logic                desched_q, desched_d;
    logic [addrBits-1:0] tx_pid_q, tx_pid_d;
    logic [dataBits-1:0] msg_q, msg_d;
    logic                error_q, error_d;

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        pid_d      = pid_q;
        address_d  = address_q;
        rw_d       = rw_q;
        data_in_d  = data_in_q;
        finished_d = finished_q;
        sched_d    = sched_q;
        desched_d  = desched_q;
        tx_pid_d   = tx_pid_q;
        msg_d      = msg_q;
        error_d    = error_q;

        // Memory controls are registered, so each state sets up the next state's access.
        unique case (state_q)
            S_IDLE: begin
                rw_d       = 1'b0;
                finished_d = 1'b0;
                if (start) begin
                    chan_d    = channel;
                    pid_d     = rxPid;
                    address_d = channel;
                    sched_d   = 1'b0;
                    desched_d = 1'b0;
                    tx_pid_d  = '0;
                    msg_d     = '0;
                    error_d   = 1'b0;
                    state_d   = S_READ_PID;
                end
            end
            S_READ_PID: state_d = S_CHECK;
            S_CHECK: begin
                if (dataOut == '0) begin
                    address_d  = chan_q;
                    rw_d       = 1'b1;
                    data_in_d  = dataBits'(pid_q);
                    desched_d  = 1'b1;
                    finished_d = 1'b1;
                    state_d    = S_WRITE_PID;
                end else if (dataOut[addrBits-1:0] == pid_q) begin
                    error_d    = 1'b1;
                    finished_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    tx_pid_d  = dataOut[addrBits-1:0];
                    address_d = chan_q + addrBits'(1);
                    state_d   = S_READ_MSG;
                end
            end
            S_READ_MSG: state_d = S_LATCH_MSG;
            S_LATCH_MSG: begin
                msg_d      = dataOut;
                address_d  = chan_q;
                rw_d       = 1'b1;
                data_in_d  = '0;
                sched_d    = 1'b1;
                finished_d = 1'b1;
                state_d    = S_CLEAR;
            end
            // The write states double as the completion cycle, so finished lands on the write.
            S_WRITE_PID, S_CLEAR, S_DONE: begin
                rw_d       = 1'b0;
                finished_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            chan_q     <= '0;
            pid_q      <= '0;
            address_q  <= '0;
            rw_q       <= 1'b0;
            data_in_q  <= '0;
            finished_q <= 1'b0;
            sched_q    <= 1'b0;
            desched_q  <= 1'b0;
            tx_pid_q   <= '0;
            msg_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            pid_q      <= pid_d;
            address_q  <= address_d;
            rw_q       <= rw_d;
            data_in_q  <= data_in_d;
            finished_q <= finished_d;
            sched_q    <= sched_d;
            desched_q  <= desched_d;
            tx_pid_q   <= tx_pid_d;
            msg_q      <= msg_d;
            error_q    <= error_d;
        end
    end

    assign address                  = address_q;
    assign readWriteMode            = rw_q;
    assign dataIn                   = data_in_q;
    assign finished                 = finished_q;
    assign shouldScheduleSender     = sched_q;
    assign shouldDescheduleReceiver = desched_q;
    assign scheduleTxPid            = tx_pid_q;
    assign deliveredMessage         = msg_q;
    assign error                    = error_q;
    assign dbg_state                = state_q;

endmodule
